// File: rtl/mac_frame_parser.sv
// mac_frame_parser: ingress header stage ahead of mac_learning.
// Collects the 12-byte MAC header, issues one learn/lookup request per
// frame, drains the payload and presents the forwarding decision.
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_in_valid/i_in_data      byte stream, byte 0 first on the wire
//   i_in_last, i_in_port      end-of-frame marker, ingress port (byte 0)
//   o_in_ready                byte accepted when valid && ready
//   o_learn_en                one-cycle request pulse to mac_learning
//   o_dst_mac/o_src_mac       captured header addresses (request operands)
//   o_src_port                ingress port of the requesting frame
//   i_learn_done              mac_learning completion pulse
//   i_learn_dst_port          lookup result, valid with i_learn_done
//   o_res_valid/i_res_ready   decision handshake to the switch fabric
//   o_res_dst_port            egress port, 0 = flood/unknown
//   o_res_src_port            ingress port of the decided frame
//   o_res_bcast               destination is the broadcast address
//   o_res_timeout             decision forced by the done timeout
//   o_runt_cnt                saturating count of runt frames
module mac_frame_parser #(
    parameter int DONE_TIMEOUT  = 64,
    parameter int MIN_HDR_BYTES = 12
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_in_valid,
    input  logic [7:0]  i_in_data,
    input  logic        i_in_last,
    input  logic [2:0]  i_in_port,
    output logic        o_in_ready,
    output logic        o_learn_en,
    output logic [47:0] o_dst_mac,
    output logic [47:0] o_src_mac,
    output logic [2:0]  o_src_port,
    input  logic        i_learn_done,
    input  logic [2:0]  i_learn_dst_port,
    output logic        o_res_valid,
    input  logic        i_res_ready,
    output logic [2:0]  o_res_dst_port,
    output logic [2:0]  o_res_src_port,
    output logic        o_res_bcast,
    output logic        o_res_timeout,
    output logic [15:0] o_runt_cnt
);

    localparam int         TW       = $clog2(DONE_TIMEOUT + 1);
    localparam logic [3:0] LAST_HDR = 4'(MIN_HDR_BYTES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HDR    = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_RESULT = 3'd4;

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [3:0]    r_hcnt;
    logic [87:0]   r_hdr;
    logic [2:0]    r_in_port;
    logic          r_lookup_pend;
    logic [TW-1:0] r_to_cnt;

    logic          r_learn_en;
    logic [47:0]   r_dst_mac;
    logic [47:0]   r_src_mac;
    logic [2:0]    r_src_port;
    logic [2:0]    r_res_dst_port;
    logic [2:0]    r_res_src_port;
    logic          r_res_bcast;
    logic          r_res_timeout;
    logic [15:0]   r_runt_cnt;

    logic          w_accept;
    logic [95:0]   w_hdr_full;
    logic          w_byte11;
    logic          w_runt;
    logic          w_lk_done;
    logic          w_lk_to;
    logic          w_resolved;

    assign o_in_ready = (r_state == S_IDLE) ||
                        (r_state == S_HDR)  ||
                        (r_state == S_DRAIN);
    assign o_res_valid = (r_state == S_RESULT);

    assign w_accept   = i_in_valid && o_in_ready;
    // Header bytes 0..10 sit in r_hdr; the byte on the bus completes it.
    assign w_hdr_full = {r_hdr, i_in_data};
    assign w_byte11   = w_accept && (r_state == S_HDR) &&
                        (r_hcnt == LAST_HDR);
    assign w_runt     = w_accept && i_in_last &&
                        ((r_state == S_IDLE) ||
                         ((r_state == S_HDR) && (r_hcnt < LAST_HDR)));

    // Done beats a timeout expiring in the same cycle.
    assign w_lk_done  = r_lookup_pend && i_learn_done;
    assign w_lk_to    = r_lookup_pend && !i_learn_done &&
                        (r_to_cnt == TW'(DONE_TIMEOUT));
    assign w_resolved = !r_lookup_pend || w_lk_done || w_lk_to;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !i_in_last)
                    w_state_nxt = S_HDR;
            end
            S_HDR: begin
                if (w_accept) begin
                    if (r_hcnt == LAST_HDR)
                        w_state_nxt = i_in_last ? S_WAIT : S_DRAIN;
                    else if (i_in_last)
                        w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                // Skip WAIT when the lookup resolves with the last byte.
                if (w_accept && i_in_last)
                    w_state_nxt = w_resolved ? S_RESULT : S_WAIT;
            end
            S_WAIT: begin
                if (w_resolved)
                    w_state_nxt = S_RESULT;
            end
            S_RESULT: begin
                if (i_res_ready)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Header capture: shift register advances only on accepted bytes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hcnt    <= 4'd0;
            r_hdr     <= '0;
            r_in_port <= 3'd0;
        end else if (w_accept) begin
            if (r_state == S_IDLE) begin
                r_hcnt    <= 4'd1;
                r_hdr     <= w_hdr_full[87:0];
                r_in_port <= i_in_port;
            end else if (r_state == S_HDR) begin
                r_hcnt <= r_hcnt + 4'd1;
                r_hdr  <= w_hdr_full[87:0];
            end
        end
    end

    // Request operands move only when a complete header arrives, which
    // cannot happen before the previous decision has been accepted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_learn_en     <= 1'b0;
            r_dst_mac      <= '0;
            r_src_mac      <= '0;
            r_src_port     <= 3'd0;
            r_res_src_port <= 3'd0;
            r_res_bcast    <= 1'b0;
        end else begin
            r_learn_en <= w_byte11;
            if (w_byte11) begin
                r_dst_mac      <= w_hdr_full[95:48];
                r_src_mac      <= w_hdr_full[47:0];
                r_src_port     <= r_in_port;
                r_res_src_port <= r_in_port;
                r_res_bcast    <= &w_hdr_full[95:48];
            end
        end
    end

    // Lookup tracking runs alongside the payload drain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lookup_pend  <= 1'b0;
            r_to_cnt       <= '0;
            r_res_dst_port <= 3'd0;
            r_res_timeout  <= 1'b0;
        end else if (w_byte11) begin
            r_lookup_pend  <= 1'b1;
            r_to_cnt       <= '0;
            r_res_dst_port <= 3'd0;
            r_res_timeout  <= 1'b0;
        end else if (w_lk_done) begin
            r_lookup_pend  <= 1'b0;
            // Broadcast still learns the source but always floods.
            r_res_dst_port <= r_res_bcast ? 3'd0 : i_learn_dst_port;
        end else if (w_lk_to) begin
            r_lookup_pend  <= 1'b0;
            r_res_dst_port <= 3'd0;
            r_res_timeout  <= 1'b1;
        end else if (r_lookup_pend) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_runt_cnt <= 16'd0;
        end else if (w_runt && (r_runt_cnt != 16'hFFFF)) begin
            r_runt_cnt <= r_runt_cnt + 16'd1;
        end
    end

    assign o_learn_en     = r_learn_en;
    assign o_dst_mac      = r_dst_mac;
    assign o_src_mac      = r_src_mac;
    assign o_src_port     = r_src_port;
    assign o_res_dst_port = r_res_dst_port;
    assign o_res_src_port = r_res_src_port;
    assign o_res_bcast    = r_res_bcast;
    assign o_res_timeout  = r_res_timeout;
    assign o_runt_cnt     = r_runt_cnt;

endmodule

// File: tb/tb_mac_frame_parser.sv
// tb_mac_frame_parser: scoreboard bench for mac_frame_parser.
// Drives frames, models mac_learning latency and checks each decision.
module tb_mac_frame_parser;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_in_valid;
    logic [7:0]  i_in_data;
    logic        i_in_last;
    logic [2:0]  i_in_port;
    logic        o_in_ready;
    logic        o_learn_en;
    logic [47:0] o_dst_mac;
    logic [47:0] o_src_mac;
    logic [2:0]  o_src_port;
    logic        i_learn_done;
    logic [2:0]  i_learn_dst_port;
    logic        o_res_valid;
    logic        i_res_ready;
    logic [2:0]  o_res_dst_port;
    logic [2:0]  o_res_src_port;
    logic        o_res_bcast;
    logic        o_res_timeout;
    logic [15:0] o_runt_cnt;

    mac_frame_parser #(.DONE_TIMEOUT(64), .MIN_HDR_BYTES(12)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_in_valid(i_in_valid), .i_in_data(i_in_data),
        .i_in_last(i_in_last), .i_in_port(i_in_port),
        .o_in_ready(o_in_ready), .o_learn_en(o_learn_en),
        .o_dst_mac(o_dst_mac), .o_src_mac(o_src_mac),
        .o_src_port(o_src_port), .i_learn_done(i_learn_done),
        .i_learn_dst_port(i_learn_dst_port),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
        .o_res_dst_port(o_res_dst_port),
        .o_res_src_port(o_res_src_port),
        .o_res_bcast(o_res_bcast), .o_res_timeout(o_res_timeout),
        .o_runt_cnt(o_runt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [47:0] dst;
        logic [47:0] src;
        logic [2:0]  port;
        logic [2:0]  rdp;
        logic        bc;
        logic        to;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] frm[$];
    int         n_err = 0;
    int         n_chk = 0;
    int         learn_cnt = 0;
    int         exp_learn = 0;
    int         done_lat = 5;
    logic [2:0] done_port = 3'd0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic build(input logic [47:0] dst, input logic [47:0] src,
                         input int len);
        logic [95:0] h;
        h = {dst, src};
        frm.delete();
        for (int i = 0; i < len; i++) begin
            if (i < 12) frm.push_back(h[95 - 8*i -: 8]);
            else        frm.push_back(8'(i * 7));
        end
    endtask

    task automatic prep(input logic [47:0] dst, input logic [47:0] src,
                        input logic [2:0] port, input int len,
                        input int lat, input logic [2:0] dp,
                        input bit to);
        exp_t e;
        build(dst, src, len);
        done_lat  = lat;
        done_port = dp;
        e.dst  = dst;
        e.src  = src;
        e.port = port;
        e.bc   = (dst == 48'hFFFF_FFFF_FFFF);
        e.rdp  = (e.bc || to) ? 3'd0 : dp;
        e.to   = to;
        sb.push_back(e);
        exp_learn++;
    endtask

    // Entered and left on a negedge; inputs change only there.
    task automatic send_frame(input logic [2:0] port, input int start,
                              input int stop);
        int w;
        for (int i = start; i < stop; i++) begin
            i_in_valid = 1'b1;
            i_in_data  = frm[i];
            i_in_last  = (i == frm.size() - 1);
            i_in_port  = port;
            w = 0;
            while (!o_in_ready && w < 300) begin
                @(negedge clk);
                w++;
            end
            if (w >= 300) check("in_ready_wait", 0, 1);
            @(negedge clk);
        end
        i_in_valid = 1'b0;
        i_in_last  = 1'b0;
    endtask

    task automatic wait_empty(input int bound);
        int n;
        n = 0;
        while (sb.size() > 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (n >= bound) check("drain_wait", sb.size(), 0);
    endtask

    // mac_learning model: done pulse done_lat cycles after learn_en.
    initial begin
        int cd;
        cd = 0;
        i_learn_done     = 1'b0;
        i_learn_dst_port = 3'd0;
        forever begin
            @(negedge clk);
            i_learn_done = 1'b0;
            if (cd == 1) begin
                i_learn_done     = 1'b1;
                i_learn_dst_port = done_port;
            end
            if (cd > 0) cd--;
            if (o_learn_en && !i_rst) cd = done_lat;
        end
    end

    // Output monitor, sampled after the negedge input updates settle.
    initial begin
        exp_t        e;
        bit          mac_act;
        logic [98:0] mac_snap;
        bit          pv;
        logic [7:0]  pres;
        mac_act = 0;
        pv = 0;
        pres = '0;
        mac_snap = '0;
        forever begin
            @(negedge clk);
            #2;
            if (mac_act && !o_learn_en)
                check("mac_hold", {o_dst_mac, o_src_mac, o_src_port},
                      mac_snap);
            if (pv && o_res_valid)
                check("res_hold", {o_res_dst_port, o_res_src_port,
                      o_res_bcast, o_res_timeout}, pres);
            if (o_learn_en) begin
                learn_cnt++;
                if (sb.size() == 0) begin
                    check("spurious_learn_en", 1, 0);
                end else begin
                    check("learn_dst_mac", o_dst_mac, sb[0].dst);
                    check("learn_src_mac", o_src_mac, sb[0].src);
                    check("learn_src_port", o_src_port, sb[0].port);
                end
                mac_act  = 1;
                mac_snap = {o_dst_mac, o_src_mac, o_src_port};
            end
            if (o_res_valid && sb.size() == 0)
                check("spurious_res_valid", 1, 0);
            if (o_res_valid && i_res_ready && sb.size() > 0) begin
                e = sb.pop_front();
                check("res_dst_port", o_res_dst_port, e.rdp);
                check("res_src_port", o_res_src_port, e.port);
                check("res_bcast", o_res_bcast, e.bc);
                check("res_timeout", o_res_timeout, e.to);
                check("res_dst_mac", o_dst_mac, e.dst);
                mac_act = 0;
            end
            pv   = o_res_valid && !i_res_ready;
            pres = {o_res_dst_port, o_res_src_port,
                    o_res_bcast, o_res_timeout};
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         k;
        int         bad_rdy;
        int         bad_hold;
        logic [7:0]  rsnap;
        logic [95:0] msnap;

        i_rst       = 1'b1;
        i_in_valid  = 1'b0;
        i_in_data   = 8'h00;
        i_in_last   = 1'b0;
        i_in_port   = 3'd0;
        i_res_ready = 1'b1;

        // A one-byte frame offered during reset must be ignored.
        @(negedge clk);
        i_in_valid = 1'b1;
        i_in_data  = 8'hAA;
        i_in_last  = 1'b1;
        repeat (3) @(negedge clk);
        i_rst      = 1'b0;
        i_in_valid = 1'b0;
        i_in_last  = 1'b0;

        check("rst_in_ready", o_in_ready, 1);
        check("rst_learn_en", o_learn_en, 0);
        check("rst_res_valid", o_res_valid, 0);
        check("rst_dst_mac", o_dst_mac, 0);
        check("rst_src_mac", o_src_mac, 0);
        check("rst_src_port", o_src_port, 0);
        check("rst_res_dst_port", o_res_dst_port, 0);
        check("rst_res_src_port", o_res_src_port, 0);
        check("rst_res_bcast", o_res_bcast, 0);
        check("rst_res_timeout", o_res_timeout, 0);
        @(negedge clk);
        check("rst_runt_cnt", o_runt_cnt, 0);

        // 64-byte unicast frame.
        prep(48'h0011_2233_4455, 48'h6677_8899_AABB, 3'd2, 64, 5, 3'd3, 0);
        send_frame(3'd2, 0, 64);
        wait_empty(200);
        check("learn_cnt_t1", learn_cnt, 1);

        // 8-byte runt, then a minimal 12-byte frame with latency check.
        build(48'h0A0B_0C0D_0E0F, 48'h1020_3040_5060, 8);
        send_frame(3'd1, 0, 8);
        check("runt_cnt", o_runt_cnt, 1);
        repeat (10) @(negedge clk);
        check("runt_no_learn", learn_cnt, 1);
        prep(48'h0A0B_0C0D_0E0F, 48'h1020_3040_5060, 3'd4, 12, 5, 3'd6, 0);
        send_frame(3'd4, 0, 12);
        k = 1;
        while (!o_res_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("res_latency", k, 7);
        wait_empty(100);

        // Broadcast still learns but floods.
        prep(48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 3'd1, 20, 5, 3'd5, 0);
        send_frame(3'd1, 0, 20);
        wait_empty(100);
        check("bcast_learned", learn_cnt, 3);

        // Latency boundaries: 1 cycle, and exactly the timeout.
        prep(48'h0000_0000_0007, 48'h0000_0000_0008, 3'd7, 13, 1, 3'd7, 0);
        send_frame(3'd7, 0, 13);
        wait_empty(100);
        prep(48'h0000_0000_0009, 48'h0000_0000_000A, 3'd3, 12, 64, 3'd2, 0);
        send_frame(3'd3, 0, 12);
        wait_empty(200);

        // Done withheld past the timeout, arrives late at cycle 70.
        i_res_ready = 1'b0;
        prep(48'h0000_1111_2222, 48'h0000_3333_4444, 3'd5, 12, 70, 3'd4, 1);
        send_frame(3'd5, 0, 12);
        repeat (90) @(negedge clk);
        check("to_res_valid", o_res_valid, 1);
        check("to_res_timeout", o_res_timeout, 1);
        check("to_res_dst_port", o_res_dst_port, 0);
        i_res_ready = 1'b1;
        wait_empty(20);

        // Decision stalled for 20 cycles while the next frame waits.
        i_res_ready = 1'b0;
        prep(48'h1111_1111_1111, 48'h2222_2222_2222, 3'd0, 16, 3, 3'd1, 0);
        send_frame(3'd0, 0, 16);
        k = 0;
        while (!o_res_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("stall_res_valid", o_res_valid, 1);
        rsnap = {o_res_dst_port, o_res_src_port, o_res_bcast, o_res_timeout};
        msnap = {o_dst_mac, o_src_mac};
        prep(48'h3333_3333_3333, 48'h4444_4444_4444, 3'd6, 12, 5, 3'd2, 0);
        i_in_valid = 1'b1;
        i_in_data  = frm[0];
        i_in_last  = 1'b0;
        i_in_port  = 3'd6;
        bad_rdy  = 0;
        bad_hold = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_in_ready) bad_rdy++;
            if ({o_res_dst_port, o_res_src_port, o_res_bcast,
                 o_res_timeout} != rsnap) bad_hold++;
            if ({o_dst_mac, o_src_mac} != msnap) bad_hold++;
        end
        check("stall_in_ready_low", bad_rdy, 0);
        check("stall_outputs_held", bad_hold, 0);
        i_res_ready = 1'b1;
        @(negedge clk);
        check("b0_ready_after_hs", o_in_ready, 1);
        @(negedge clk);
        send_frame(3'd6, 1, 12);
        wait_empty(100);

        // Reset on byte 5 drops the frame and clears everything.
        build(48'h5555_5555_5555, 48'h6666_6666_6666, 20);
        send_frame(3'd3, 0, 5);
        i_in_valid = 1'b1;
        i_in_data  = frm[5];
        i_rst      = 1'b1;
        repeat (2) @(negedge clk);
        i_rst      = 1'b0;
        i_in_valid = 1'b0;
        check("mid_rst_dst_mac", o_dst_mac, 0);
        check("mid_rst_src_mac", o_src_mac, 0);
        check("mid_rst_src_port", o_src_port, 0);
        check("mid_rst_runt_cnt", o_runt_cnt, 0);
        check("mid_rst_res_src", o_res_src_port, 0);
        check("mid_rst_in_ready", o_in_ready, 1);
        repeat (30) @(negedge clk);
        check("mid_rst_no_learn", learn_cnt, exp_learn);
        check("mid_rst_res_valid", o_res_valid, 0);

        // Recovery frame after the reset.
        prep(48'h7777_0000_0001, 48'h8888_0000_0002, 3'd3, 12, 2, 3'd5, 0);
        send_frame(3'd3, 0, 12);
        wait_empty(100);

        repeat (5) @(negedge clk);
        check("learn_total", learn_cnt, exp_learn);
        check("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
